// File: rtl/pmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter_if
// Purpose  : Cache-side request/response bus and physical-memory port
//            bundled for the pmem arbiter.
// Revision : 1.0
// ============================================================================
interface pmem_arbiter_if #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) ();
    logic [N_CH-1:0]        ch_read;
    logic [N_CH-1:0]        ch_write;
    logic [N_CH*ADDR_W-1:0] ch_address;
    logic [N_CH*LINE_W-1:0] ch_wdata;
    logic [LINE_W-1:0]      ch_rdata;
    logic [N_CH-1:0]        ch_resp;
    logic                   pmem_read;
    logic                   pmem_write;
    logic [ADDR_W-1:0]      pmem_address;
    logic [LINE_W-1:0]      pmem_wdata;
    logic [LINE_W-1:0]      pmem_rdata;
    logic                   pmem_resp;

    // master: the arbiter (serves the caches, issues pmem transactions)
    modport master (
        input  ch_read, ch_write, ch_address, ch_wdata, pmem_rdata, pmem_resp,
        output ch_rdata, ch_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    // slave: the environment (requesting caches plus physical memory)
    modport slave (
        output ch_read, ch_write, ch_address, ch_wdata, pmem_rdata, pmem_resp,
        input  ch_rdata, ch_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter
// Purpose  : Round-robin sharing of one pmem line port among N_CH requesters.
//            Optional macro PMEM_ARB_WRITE_PRIO_EN favours pending writes.
// Revision : 1.0
// ============================================================================
module pmem_arbiter #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    pmem_arbiter_if.master bus
);
    localparam int            GW      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [GW-1:0] LAST_CH = GW'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic                is_write_q, is_write_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LINE_W-1:0]   rdata_q, rdata_d;

    logic [N_CH-1:0]     eligible;
    logic [GW-1:0]       cand;
    logic [GW-1:0]       pick;
    logic                found;
    logic [N_CH-1:0]     resp_vec;

    always_comb begin
`ifdef PMEM_ARB_WRITE_PRIO_EN
        // Writebacks drain before refills: reads compete only when no write is pending.
        eligible = (|bus.ch_write) ? bus.ch_write : (bus.ch_read | bus.ch_write);
`else
        eligible = bus.ch_read | bus.ch_write;
`endif
    end

    // Walk last_grant+1, last_grant+2, ... with wrap; first eligible channel wins.
    always_comb begin
        cand  = last_grant_q;
        pick  = last_grant_q;
        found = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            cand = (cand == LAST_CH) ? '0 : cand + GW'(1);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        is_write_d   = is_write_q;
        address_d    = address_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d    = pick;
                    // Read and write together is treated as a write.
                    is_write_d = bus.ch_write[pick];
                    for (int i = 0; i < N_CH; i++) begin
                        if (GW'(i) == pick) begin
                            address_d = bus.ch_address[i*ADDR_W +: ADDR_W];
                            wdata_d   = bus.ch_wdata[i*LINE_W +: LINE_W];
                        end
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.pmem_resp) begin
                    if (!is_write_q) begin
                        rdata_d = bus.pmem_rdata;
                    end
                    last_grant_d = grant_q;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_CH;
            is_write_q   <= 1'b0;
            address_q    <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            is_write_q   <= is_write_d;
            address_q    <= address_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        resp_vec = '0;
        if (state_q == RESP) begin
            resp_vec[grant_q] = 1'b1;
        end
    end

    assign bus.pmem_read    = (state_q == BUSY) && !is_write_q;
    assign bus.pmem_write   = (state_q == BUSY) &&  is_write_q;
    assign bus.pmem_address = address_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.ch_rdata     = rdata_q;
    assign bus.ch_resp      = resp_vec;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_arbiter
// Purpose  : Directed self-checking bench for pmem_arbiter (N_CH=2 and N_CH=4).
// Revision : 1.0
// ============================================================================
module tb_pmem_arbiter;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
    typedef logic [LINE_W-1:0] v_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pmem_arbiter_if #(.N_CH(2), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus2 ();
    pmem_arbiter_if #(.N_CH(4), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus4 ();

    pmem_arbiter #(.N_CH(2), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.master)
    );

    pmem_arbiter #(.N_CH(4), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input v_t obs, input v_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v_t a5_line;
        v_t wr_line;
        v_t exp_resp;
        a5_line = {32{8'hA5}};
        wr_line = {8{32'h1234_5678}};

        rst_n = 1'b0;
        bus2.ch_read = '0;  bus2.ch_write = '0;  bus2.ch_address = '0;  bus2.ch_wdata = '0;
        bus2.pmem_rdata = '0; bus2.pmem_resp = 1'b0;
        bus4.ch_read = '0;  bus4.ch_write = '0;  bus4.ch_address = '0;  bus4.ch_wdata = '0;
        bus4.pmem_rdata = '0; bus4.pmem_resp = 1'b0;
        tick(); tick();
        chk("rst_pmem_read",  v_t'(bus2.pmem_read),    v_t'(0));
        chk("rst_pmem_addr",  v_t'(bus2.pmem_address), v_t'(0));
        chk("rst_ch_rdata",   bus2.ch_rdata,           v_t'(0));
        rst_n = 1'b1;
        tick();

        // Reset asserted while a read is in flight abandons it at once
        bus2.ch_read = 2'b01; bus2.ch_address[31:0] = 32'h0000_0777;
        tick();
        chk("abort_busy_read", v_t'(bus2.pmem_read), v_t'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_read_low", v_t'(bus2.pmem_read),    v_t'(0));
        chk("abort_addr_clr", v_t'(bus2.pmem_address), v_t'(0));
        bus2.ch_read = '0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("idle_read",  v_t'(bus2.pmem_read),  v_t'(0));
        chk("idle_write", v_t'(bus2.pmem_write), v_t'(0));
        chk("idle_resp",  v_t'(bus2.ch_resp),    v_t'(0));

        // Single read on channel 0, memory answers three cycles later
        bus2.ch_read = 2'b01; bus2.ch_address[31:0] = 32'h0000_1000;
        tick();
        chk("rd_pmem_read",  v_t'(bus2.pmem_read),    v_t'(1));
        chk("rd_pmem_write", v_t'(bus2.pmem_write),   v_t'(0));
        chk("rd_addr",       v_t'(bus2.pmem_address), v_t'(32'h0000_1000));
        bus2.ch_address[31:0] = 32'hFFFF_0000;
        tick(); tick();
        chk("rd_addr_held",  v_t'(bus2.pmem_address), v_t'(32'h0000_1000));
        bus2.pmem_resp = 1'b1; bus2.pmem_rdata = a5_line;
        tick();
        bus2.pmem_resp = 1'b0; bus2.pmem_rdata = '0;
        chk("rd_read_drop", v_t'(bus2.pmem_read), v_t'(0));
        chk("rd_ch_resp",   v_t'(bus2.ch_resp),   v_t'(2'b01));
        chk("rd_ch_rdata",  bus2.ch_rdata,        a5_line);
        bus2.ch_read = '0;
        tick();
        chk("rd_resp_once", v_t'(bus2.ch_resp), v_t'(0));

        // Single write on channel 1; returned pmem_rdata must not reach ch_rdata
        bus2.ch_write = 2'b10; bus2.ch_address[63:32] = 32'h0000_2020;
        bus2.ch_wdata[511:256] = wr_line;
        tick();
        chk("wr_pmem_write", v_t'(bus2.pmem_write),   v_t'(1));
        chk("wr_pmem_read",  v_t'(bus2.pmem_read),    v_t'(0));
        chk("wr_addr",       v_t'(bus2.pmem_address), v_t'(32'h0000_2020));
        chk("wr_wdata",      bus2.pmem_wdata,         wr_line);
        tick();
        bus2.pmem_resp = 1'b1; bus2.pmem_rdata = {8{32'hDEAD_BEEF}};
        tick();
        bus2.pmem_resp = 1'b0; bus2.pmem_rdata = '0;
        chk("wr_ch_resp",   v_t'(bus2.ch_resp), v_t'(2'b10));
        chk("wr_rdata_kept", bus2.ch_rdata,     a5_line);
        bus2.ch_write = '0;
        tick();

        // Stray pmem_resp while idle is ignored
        bus2.pmem_resp = 1'b1;
        tick();
        bus2.pmem_resp = 1'b0;
        chk("stray_resp",  v_t'(bus2.ch_resp),   v_t'(0));
        chk("stray_state", v_t'(bus2.pmem_read), v_t'(0));

        // Round robin with both channels reading continuously: 0,1,0,1
        bus2.ch_address = {32'h0000_0200, 32'h0000_0100};
        bus2.ch_read = 2'b11;
        tick();
        for (int n = 0; n < 4; n++) begin
            chk("rr_addr", v_t'(bus2.pmem_address),
                (n % 2 == 0) ? v_t'(32'h0000_0100) : v_t'(32'h0000_0200));
            chk("rr_read", v_t'(bus2.pmem_read), v_t'(1));
            bus2.pmem_resp = 1'b1;
            tick();
            bus2.pmem_resp = 1'b0;
            chk("rr_resp", v_t'(bus2.ch_resp),
                (n % 2 == 0) ? v_t'(2'b01) : v_t'(2'b10));
            tick();
            chk("rr_idle_gap", v_t'(bus2.pmem_read), v_t'(0));
            if (n == 3) bus2.ch_read = '0;
            tick();
        end
        chk("rr_done_idle", v_t'(bus2.pmem_read), v_t'(0));

        // last_grant is now 1: read on ch0 versus write on ch1
        bus2.ch_read = 2'b01;  bus2.ch_address[31:0]  = 32'h0000_3000;
        bus2.ch_write = 2'b10; bus2.ch_address[63:32] = 32'h0000_4000;
        bus2.ch_wdata[511:256] = {8{32'hCAFE_F00D}};
        tick();
`ifdef PMEM_ARB_WRITE_PRIO_EN
        chk("prio_write", v_t'(bus2.pmem_write),   v_t'(1));
        chk("prio_addr",  v_t'(bus2.pmem_address), v_t'(32'h0000_4000));
        exp_resp = v_t'(2'b10);
`else
        chk("prio_read",  v_t'(bus2.pmem_read),    v_t'(1));
        chk("prio_addr",  v_t'(bus2.pmem_address), v_t'(32'h0000_3000));
        exp_resp = v_t'(2'b01);
`endif
        bus2.pmem_resp = 1'b1;
        tick();
        bus2.pmem_resp = 1'b0;
        chk("prio_resp", v_t'(bus2.ch_resp), exp_resp);
        bus2.ch_read = '0; bus2.ch_write = '0;
        tick();

        // Read and write together on one channel is a write
        bus2.ch_read = 2'b01; bus2.ch_write = 2'b01; bus2.ch_address[31:0] = 32'h0000_5000;
        tick();
        chk("both_write", v_t'(bus2.pmem_write), v_t'(1));
        chk("both_read",  v_t'(bus2.pmem_read),  v_t'(0));
        bus2.pmem_resp = 1'b1;
        tick();
        bus2.pmem_resp = 1'b0;
        chk("both_resp", v_t'(bus2.ch_resp), v_t'(2'b01));
        bus2.ch_read = '0; bus2.ch_write = '0;
        tick();

        // Four channels: serve ch3, then ch2+ch0 request -> wrap to 0, then 2
        bus4.ch_address = {32'h0000_3300, 32'h0000_2200, 32'h0000_1100, 32'h0000_0A00};
        bus4.ch_read = 4'b1000;
        tick();
        chk("w4_ch3_addr", v_t'(bus4.pmem_address), v_t'(32'h0000_3300));
        bus4.pmem_resp = 1'b1;
        tick();
        bus4.pmem_resp = 1'b0;
        chk("w4_ch3_resp", v_t'(bus4.ch_resp), v_t'(4'b1000));
        bus4.ch_read = '0;
        tick();
        bus4.ch_read = 4'b0101;
        tick();
        chk("w4_wrap_addr", v_t'(bus4.pmem_address), v_t'(32'h0000_0A00));
        bus4.pmem_resp = 1'b1;
        tick();
        bus4.pmem_resp = 1'b0;
        chk("w4_wrap_resp", v_t'(bus4.ch_resp), v_t'(4'b0001));
        bus4.ch_read = 4'b0100;
        tick(); tick();
        chk("w4_next_addr", v_t'(bus4.pmem_address), v_t'(32'h0000_2200));
        bus4.pmem_resp = 1'b1;
        tick();
        bus4.pmem_resp = 1'b0;
        chk("w4_next_resp", v_t'(bus4.ch_resp), v_t'(4'b0100));
        bus4.ch_read = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
